add_share_arb: RTL

- Time-shares one 32-bit combinational ripple adder (a + b mod 2^32, no carry-out) among N requesters.
- Each requester has a valid/ready request channel and a valid/ready response channel. Grants are round-robin.
- Operands are registered before the adder and the sum is registered after it, so the ripple path is a multicycle path of CALC_CYCLES.
- Sits between pipeline stages/units that need occasional 32-bit adds and the single shared adder instance.

---
 rtl/add_share_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/add_share_arb.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/add_share_pkg.sv
// Shared types and constants for the add_share_arb shared-adder arbiter.
package add_share_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Ceiling log2, used to cross-check IDW against N at elaboration.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches i_req starting at i_rr_ptr
// (taken modulo N) and returns the first valid requester.
module rr_arbiter
  import add_share_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_rr_ptr,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_idx,
  output logic           o_any
);

  logic [IDW-1:0] w_cand;

  // First valid requester at or after the pointer, wrapping modulo N.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Modulo keeps out-of-range pointers (non power-of-two N) from aliasing.
      w_cand = IDW'((32'(i_rr_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_gnt_idx     = w_cand;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_share_arb.sv
// Time-shares one 32-bit adder among N valid/ready requesters with
// round-robin grants. Operands and sum are registered around the adder so
// the ripple path is a CALC_CYCLES multicycle path.
// Optional macro ADD_SHARE_ARB_OVF_EN adds the rsp_ovf signed-overflow output.
module add_share_arb
  import add_share_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned IDW         = 2,
  parameter int unsigned CALC_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req_valid,
  output logic [N-1:0]        req_ready,
  input  logic [N*DATA_W-1:0] req_a,
  input  logic [N*DATA_W-1:0] req_b,
  output logic [N-1:0]        rsp_valid,
  input  logic [N-1:0]        rsp_ready,
  output logic [DATA_W-1:0]   rsp_sum,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
`ifdef ADD_SHARE_ARB_OVF_EN
  ,
  output logic                rsp_ovf
`endif
);

  if (IDW != clog2_u(N) || N < 2 || N > 8 || CALC_CYCLES < 1 || CALC_CYCLES > 4) begin : g_bad_cfg
    $error("add_share_arb: illegal N/IDW/CALC_CYCLES combination");
  end

  localparam logic [2:0] CNT_LAST = 3'(CALC_CYCLES - 1);

  state_t              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_gid;
  logic [IDW-1:0]      r_rsp_id;
  logic [2:0]          r_cnt;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_sum;
  logic [N-1:0]        r_rsp_valid;
  logic [N-1:0]        w_gnt;
  logic [IDW-1:0]      w_gnt_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [DATA_W-1:0]   w_sum;
`ifdef ADD_SHARE_ARB_OVF_EN
  logic                r_ovf;
`endif

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_arb (
    .i_req     (req_valid),
    .i_rr_ptr  (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  // The single shared adder; it only ever sees the registered operands.
  assign w_sum = r_op_a + r_op_b;

  // Operand select for the current round-robin winner.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt_idx == IDW'(i)) begin
        w_sel_a = req_a[i*DATA_W +: DATA_W];
        w_sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Accept is combinational in IDLE; gated by rst_n so reset forces it low.
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != IDLE);
`ifdef ADD_SHARE_ARB_OVF_EN
  assign rsp_ovf   = r_ovf;
`endif

  // Control FSM: grant, multicycle settle count, response hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_rsp_id    <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sum       <= '0;
      r_rsp_valid <= '0;
`ifdef ADD_SHARE_ARB_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a  <= w_sel_a;
            r_op_b  <= w_sel_b;
            r_gid   <= w_gnt_idx;
            r_cnt   <= '0;
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_cnt == CNT_LAST) begin
            r_sum       <= w_sum;
            r_rsp_id    <= r_gid;
            r_rsp_valid <= N'(1) << r_gid;
`ifdef ADD_SHARE_ARB_OVF_EN
            r_ovf       <= (r_op_a[DATA_W-1] == r_op_b[DATA_W-1]) &&
                           (w_sum[DATA_W-1] != r_op_a[DATA_W-1]);
`endif
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready[r_gid]) begin
            r_rsp_valid <= '0;
            r_ptr       <= (r_gid == IDW'(N - 1)) ? '0 : r_gid + 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
